// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// bit-counter width helper used by the TX framer (and the RX checker).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    typedef logic [1:0] par_mode_t;

    localparam par_mode_t PAR_NONE = 2'b00;
    localparam par_mode_t PAR_EVEN = 2'b01;
    localparam par_mode_t PAR_ODD  = 2'b10;
    localparam par_mode_t PAR_MARK = 2'b11;

    // Bit-counter width for a word of w bits; a 1-bit word still needs a
    // 1-bit counter so the index expression stays well formed.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit generator: maps a data word and parity mode to the bit placed
// in the parity slot. Purely combinational so TX and RX can share it.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  par_mode_t             mode,
    output logic                  par_bit
);

    // Select the parity function for the requested mode; NONE yields 0 and
    // the framer never places it on the line.
    always_comb begin
        par_bit = 1'b0;
        case (mode)
            PAR_EVEN: par_bit = ^data;
            PAR_ODD:  par_bit = ~^data;
            PAR_MARK: par_bit = 1'b1;
            default:  par_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word over valid/ready, latches the word and
// its frame configuration, and shifts out start / data (LSB first) / optional
// parity / one or two stop bits, advancing one bit per baud_tick.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line high, in_ready high, waiting for a word
// ARM    | word latched, line high, waiting for a tick to align the start bit
// START  | start bit (line low) for one tick period
// DATA   | data bit bit_cnt on the line, LSB first
// PARITY | registered parity bit on the line (skipped for mode NONE)
// STOP   | line high; stop_cnt counts the second stop bit when enabled
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_par_mode,
    input  logic                  in_stop2,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    uart_state_t           state_q;
    uart_state_t           state_n;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_n;
    logic                  stop_cnt_q;
    logic                  stop_cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    par_mode_t             mode_q;
    logic                  stop2_q;
    logic                  par_q;
    logic                  par_in;
    logic                  accept;
    logic                  tx_n;
    logic                  frame_done_n;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;

    // Parity is evaluated on the word being offered so the registered bit is
    // settled long before the frame reaches the parity slot.
    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (in_data),
        .mode    (in_par_mode),
        .par_bit (par_in)
    );

    // Capture the word and its framing options once, at acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            mode_q  <= PAR_NONE;
            stop2_q <= 1'b0;
            par_q   <= 1'b0;
        end else if (accept) begin
            data_q  <= in_data;
            mode_q  <= in_par_mode;
            stop2_q <= in_stop2;
            par_q   <= par_in;
        end
    end

    // State, counters and the registered line/done outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            tx_out     <= tx_n;
            frame_done <= frame_done_n;
        end
    end

    // Next-state, counter and output decode. A tick on the acceptance cycle
    // is ignored because IDLE does not look at baud_tick.
    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        stop_cnt_n   = stop_cnt_q;
        frame_done_n = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n    = ARM;
                    bit_cnt_n  = '0;
                    stop_cnt_n = 1'b0;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_n    = (mode_q != PAR_NONE) ? PARITY : STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!stop_cnt_q && stop2_q) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        state_n      = IDLE;
                        stop_cnt_n   = 1'b0;
                        frame_done_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                bit_cnt_n  = '0;
                stop_cnt_n = 1'b0;
            end
        endcase

        // Line level follows the state being entered, so tx_out is a pure
        // register with no path from the inputs.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_q[bit_cnt_n];
            PARITY:  tx_n = par_q;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: three builds (8, 5 and 16 data bits) share
// stimulus; the active one is chosen by sel. Captured line bits are compared
// with a frame model built directly from the framing rules.
module tb_uart_tx_framer;
    import uart_pkg::*;

    localparam int TICK = 16;

    logic        CLK;
    logic        RST;
    logic        baud_tick;
    logic [15:0] in_data;
    logic [1:0]  in_par_mode;
    logic        in_stop2;
    logic        in_valid;

    int sel;
    int checks;
    int errors;
    int tdiv;

    logic rdy8, tx8, busy8, fd8;
    logic rdy5, tx5, busy5, fd5;
    logic rdy16, tx16, busy16, fd16;
    logic rdy_m, tx_m, busy_m, fd_m;
    logic v8, v5, v16;

    assign v8  = in_valid && (sel == 0);
    assign v5  = in_valid && (sel == 1);
    assign v16 = in_valid && (sel == 2);

    uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .in_data(in_data[7:0]),
        .in_par_mode(in_par_mode), .in_stop2(in_stop2), .in_valid(v8),
        .in_ready(rdy8), .tx_out(tx8), .busy(busy8), .frame_done(fd8));

    uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .in_data(in_data[4:0]),
        .in_par_mode(in_par_mode), .in_stop2(in_stop2), .in_valid(v5),
        .in_ready(rdy5), .tx_out(tx5), .busy(busy5), .frame_done(fd5));

    uart_tx_framer #(.DATA_WIDTH(16)) dut16 (
        .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .in_data(in_data),
        .in_par_mode(in_par_mode), .in_stop2(in_stop2), .in_valid(v16),
        .in_ready(rdy16), .tx_out(tx16), .busy(busy16), .frame_done(fd16));

    always_comb begin
        rdy_m = rdy8; tx_m = tx8; busy_m = busy8; fd_m = fd8;
        case (sel)
            1: begin rdy_m = rdy5;  tx_m = tx5;  busy_m = busy5;  fd_m = fd5;  end
            2: begin rdy_m = rdy16; tx_m = tx16; busy_m = busy16; fd_m = fd16; end
            default: ;
        endcase
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One-cycle tick every TICK clocks, updated shortly after the rising edge.
    initial begin
        baud_tick = 1'b0;
        tdiv = 0;
        forever begin
            @(posedge CLK);
            #3;
            tdiv = (tdiv == TICK - 1) ? 0 : tdiv + 1;
            baud_tick = (tdiv == TICK - 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 5 : (s == 2) ? 16 : 8;
    endfunction

    // Expected line bits, index 0 first on the wire.
    function automatic void frame_model(input logic [15:0] d, input int w, input logic [1:0] m,
                                        input logic s2, output logic [31:0] v, output int n);
        int ones;
        ones = 0;
        v = '0;
        n = 0;
        v[n] = 1'b0; n++;
        for (int i = 0; i < w; i++) begin
            v[n] = d[i]; n++;
            ones += int'(d[i]);
        end
        if (m != PAR_NONE) begin
            if (m == PAR_MARK)      v[n] = 1'b1;
            else if (m == PAR_EVEN) v[n] = (ones % 2 == 1);
            else                    v[n] = (ones % 2 == 0);
            n++;
        end
        v[n] = 1'b1; n++;
        if (s2) begin v[n] = 1'b1; n++; end
    endfunction

    // Offer a word on the selected build; optionally line the request up with
    // a tick and optionally keep in_valid asserted afterwards.
    task automatic accept_word(input logic [15:0] d, input logic [1:0] m, input logic s2,
                               input bit hold, input bit align_tick);
        int n;
        n = 0;
        while (!rdy_m && n < 600) begin @(negedge CLK); n++; end
        chk("ready_before_accept", rdy_m, 1);
        if (align_tick) begin
            n = 0;
            while (!baud_tick && n < 40) begin @(negedge CLK); n++; end
            chk("tick_aligned", baud_tick, 1);
        end
        in_data = d; in_par_mode = m; in_stop2 = s2; in_valid = 1'b1;
        @(negedge CLK);
        chk("accept_busy", busy_m, 1);
        chk("accept_ready_low", rdy_m, 0);
        if (!hold) begin
            in_valid = 1'b0;
            in_data = 16'($urandom);
            in_par_mode = 2'($urandom);
            in_stop2 = 1'($urandom);
        end
    endtask

    // Called on the falling edge after acceptance. Samples the line on the
    // last cycle of every tick period and checks it against the model.
    task automatic capture(input logic [15:0] d, input logic [1:0] m, input logic s2,
                           input bit scramble, output logic [31:0] act, output int nb);
        logic [31:0] ev;
        int          en;
        int          n;
        int          cnt;
        bit          arm_ok;
        bit          done;
        frame_model(d, width_of(sel), m, s2, ev, en);
        arm_ok = 1'b1;
        n = 0;
        while (!baud_tick && n < 40) begin
            if (tx_m !== 1'b1) arm_ok = 1'b0;
            @(negedge CLK);
            n++;
        end
        if (tx_m !== 1'b1) arm_ok = 1'b0;
        chk("arm_line_high", arm_ok, 1);
        act = '0;
        nb = 0;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < en * TICK + 40) begin
            @(negedge CLK);
            cnt++;
            if (fd_m) begin
                done = 1'b1;
            end else begin
                if (baud_tick) begin
                    if (nb < 32) act[nb] = tx_m;
                    nb++;
                end
                if (scramble) begin
                    in_data = 16'($urandom);
                    in_par_mode = 2'($urandom);
                    in_stop2 = 1'($urandom);
                end
            end
        end
        chk("frame_done_seen", done, 1);
        chk("frame_bits", act, ev);
        chk("frame_len", nb, en);
        chk("frame_clks", cnt - 1, en * TICK);
        chk("idle_line_high", tx_m, 1);
    endtask

    typedef struct {
        int          s;
        logic [15:0] d;
        logic [1:0]  m;
        logic        s2;
        int          len;
        logic        par;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] act;
        int          nb;
        bit          fd_seen;

        checks = 0; errors = 0; sel = 0;
        in_data = '0; in_par_mode = PAR_NONE; in_stop2 = 1'b0; in_valid = 1'b0;
        RST = 1'b0;

        vecs[0] = '{0, 16'h00A5, PAR_EVEN, 1'b0, 11, 1'b0};
        vecs[1] = '{0, 16'h00A5, PAR_ODD,  1'b0, 11, 1'b1};
        vecs[2] = '{0, 16'h0007, PAR_EVEN, 1'b0, 11, 1'b1};
        vecs[3] = '{0, 16'h0007, PAR_MARK, 1'b0, 11, 1'b1};
        vecs[4] = '{0, 16'h0007, PAR_NONE, 1'b0, 10, 1'b0};
        vecs[5] = '{0, 16'h0000, PAR_NONE, 1'b1, 11, 1'b0};
        vecs[6] = '{1, 16'h001F, PAR_EVEN, 1'b0,  8, 1'b1};
        vecs[7] = '{2, 16'hFFFF, PAR_EVEN, 1'b0, 19, 1'b0};
        vecs[8] = '{2, 16'h1234, PAR_ODD,  1'b1, 20, 1'b0};

        // Reset values while reset is held.
        repeat (3) @(negedge CLK);
        chk("rst_tx", tx8, 1);
        chk("rst_ready", rdy8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", fd8, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset during data bit 3 aborts the frame with the line forced high.
        sel = 0;
        accept_word(16'h0000, PAR_EVEN, 1'b0, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!baud_tick && n < 40) begin @(negedge CLK); n++; end
        end
        repeat (4 * TICK + 8) @(negedge CLK);
        chk("pre_rst_line_low", tx8, 0);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_tx", tx8, 1);
        chk("async_rst_ready", rdy8, 1);
        chk("async_rst_busy", busy8, 0);
        @(negedge CLK);
        RST = 1'b1;
        fd_seen = 1'b0;
        repeat (3 * TICK) begin
            @(negedge CLK);
            if (fd8) fd_seen = 1'b1;
        end
        chk("no_done_after_abort", fd_seen, 0);
        accept_word(16'h005A, PAR_EVEN, 1'b0, 1'b0, 1'b0);
        capture(16'h005A, PAR_EVEN, 1'b0, 1'b0, act, nb);

        // Table of directed frames.
        for (int i = 0; i < 9; i++) begin
            sel = vecs[i].s;
            repeat (3) @(negedge CLK);
            accept_word(vecs[i].d, vecs[i].m, vecs[i].s2, 1'b0, 1'b0);
            capture(vecs[i].d, vecs[i].m, vecs[i].s2, 1'b0, act, nb);
            chk("table_len", nb, vecs[i].len);
            if (vecs[i].m != PAR_NONE)
                chk("table_parity", act[1 + width_of(vecs[i].s)], vecs[i].par);
            if (i == 0) chk("a5_even_line", act, 32'h0000054A);
            @(negedge CLK);
            chk("done_pulse_width", fd_m, 0);
        end

        // Acceptance on the same cycle as a tick: ARM must wait for the next one.
        sel = 0;
        accept_word(16'h00C3, PAR_ODD, 1'b0, 1'b0, 1'b1);
        capture(16'h00C3, PAR_ODD, 1'b0, 1'b0, act, nb);

        // Held in_valid with inputs churning mid-frame, then back-to-back word.
        repeat (5) @(negedge CLK);
        accept_word(16'h003C, PAR_ODD, 1'b1, 1'b1, 1'b0);
        capture(16'h003C, PAR_ODD, 1'b1, 1'b1, act, nb);
        chk("ready_with_done", rdy_m, 1);
        in_data = 16'h0096; in_par_mode = PAR_EVEN; in_stop2 = 1'b0;
        @(negedge CLK);
        chk("done_one_cycle", fd_m, 0);
        chk("b2b_accept_busy", busy_m, 1);
        in_valid = 1'b0;
        capture(16'h0096, PAR_EVEN, 1'b0, 1'b0, act, nb);

        // Randomized frames across all three builds.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] d;
            logic [1:0]  m;
            logic        s2;
            sel = int'($urandom_range(0, 2));
            d   = 16'($urandom);
            m   = 2'($urandom);
            s2  = 1'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            accept_word(d, m, s2, 1'b0, 1'($urandom));
            capture(d, m, s2, 1'($urandom), act, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
